instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
// - Writer side of the instruction store: the ROM is read combinationally by fetch; this block fills it.
// - Takes a framed byte stream (UART/debug link), assembles 16-bit instruction words and writes them into instruction RAM.
// - Holds the core via CoreHold until a frame is fully received and its checksum passes.
// PARAMETERS
// - ADDR_WIDTH     10   instruction address width; max frame = 2**ADDR_WIDTH words
// - DATA_WIDTH     16   instruction word width; fixed at 2 bytes
// - SYNC_BYTE      8'hA5 frame start marker
// - HOLD_AT_RESET  1    CoreHold value out of reset (1 = core held until a load completes)
// PORTS
// - clk            in   1           system clock
// - rst            in   1           synchronous, active-high reset
// - StartLoad      in   1           1-cycle pulse: arm/restart a load
// - ByteValid      in   1           byte stream valid
// - ByteData       in   8           byte stream data
// - ByteReady      out  1           byte stream ready; a byte is accepted when ByteValid & ByteReady
// - WriteEn        out  1           instruction RAM write strobe, 1 cycle per word
// - WriteAddress   out  ADDR_WIDTH  word address
// - WriteData      out  DATA_WIDTH  word data
// - CoreHold       out  1           1 = core stalled / held in reset
// - LoadDone       out  1           frame written and checksum OK; sticky
// - LoadError      out  1           bad count or bad checksum; sticky
// BEHAVIOUR
// - Reset values:
//   - state IDLE; ByteReady=0, WriteEn=0, WriteAddress=0, WriteData=0
//   - LoadDone=0, LoadError=0, CoreHold=HOLD_AT_RESET
// - Frame format: SYNC, CNT_HI, CNT_LO, N words each sent hi byte then lo byte, then CSUM.
//   - N = {CNT_HI,CNT_LO}.
//   - CSUM = 8-bit mod-256 sum of the 2N data bytes only (sync and count bytes excluded).
// - States: IDLE, SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
// - ByteReady=1 only in SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK.
// - IDLE/DONE/ERROR + StartLoad -> SYNC:
//   - CoreHold=1, LoadDone=0, LoadError=0
//   - address counter=0, checksum=0
// - SYNC: accepted byte == SYNC_BYTE -> CNT_HI; any other byte is discarded and the state stays SYNC.
// - CNT_LO: after the low count byte is accepted:
//   - N==0 or N>2**ADDR_WIDTH -> ERROR, no writes issued
//   - otherwise -> DATA_HI
// - DATA_HI: latch the high byte -> DATA_LO.
// - DATA_LO: on accept:
//   - WriteEn=1 on the following cycle, WriteData={hi,lo}, WriteAddress=current count (write latency 1 cycle)
//   - address counter increments after the write
//   - next state DATA_HI, or CHECK once N words have been accepted
// - Full frame of 2**ADDR_WIDTH words: last write goes to the all-ones address. The counter is ADDR_WIDTH+1 bits wide and never wraps onto address 0.
// - CHECK: on accept:
//   - byte == sum -> DONE: LoadDone=1, CoreHold=0
//   - otherwise -> ERROR: LoadError=1, CoreHold stays 1
// - Words already written before an ERROR are not rolled back; CoreHold guarantees they are never executed.
// - Stall tolerance: ByteValid may drop for any number of cycles in any state; no timeout.
// - StartLoad in any non-IDLE state (mid-frame) restarts the load: -> SYNC, counters cleared.
//   - A byte offered in the same cycle is not accepted (ByteReady forced 0 that cycle).
//   - A pending WriteEn from the previous cycle still completes.
// - rst mid-frame: all outputs go to their reset values on the next edge; the partial frame is abandoned.
// - WriteEn is never asserted outside the cycle after a DATA_LO accept.
// TESTING
// - Reset -> ByteReady=0, WriteEn=0, LoadDone=0, LoadError=0, CoreHold=1 (default parameter).
// - StartLoad, bytes A5 00 02 D1 88 C2 20 3B:
//   - writes (0x000,16'hD188) and (0x001,16'hC220)
//   - LoadDone=1, CoreHold=0 one cycle after the CSUM byte is accepted
// - Same frame with CSUM 3C -> LoadError=1, CoreHold=1, LoadDone=0.
// - Count 00 00 -> ERROR, no WriteEn; count 04 01 -> ERROR, no WriteEn.
// - Bytes 00 FF 5A before A5, plus random ByteValid gaps -> same result as the clean frame.
// - StartLoad after 3 words of a 5-word frame, then a full 2-word frame:
//   - writes restart at 0x000
//   - CSUM computed over the new frame only
//   - LoadDone=1
// - 1024-word frame -> last write at 0x3FF, LoadDone=1.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-RAM write bus of the instruction loader.
// The master side is the host link that frames the bytes.
// The slave side is the loader, which also drives the RAM write port.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  StartLoad;
  logic                  ByteValid;
  logic [7:0]            ByteData;
  logic                  ByteReady;
  logic                  WriteEn;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  CoreHold;
  logic                  LoadDone;
  logic                  LoadError;

  modport master (
    output StartLoad, ByteValid, ByteData,
    input  ByteReady, WriteEn, WriteAddress, WriteData, CoreHold, LoadDone, LoadError
  );

  modport slave (
    input  StartLoad, ByteValid, ByteData,
    output ByteReady, WriteEn, WriteAddress, WriteData, CoreHold, LoadDone, LoadError
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: fills the instruction RAM from a framed byte stream.
// Frame layout: SYNC, CNT_HI, CNT_LO, N words (hi byte, then lo byte), CSUM.
// The core stays held until a frame has been written and its checksum matches.
module instruction_loader #(
  parameter int         ADDR_WIDTH    = 10,
  parameter int         DATA_WIDTH    = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input logic                clk,
  input logic                rst,
  instruction_loader_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  // Largest legal word count; one wider than the address so a full frame fits.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t                state;
  state_t                next_state;
  logic                  byte_ready;
  logic                  accept;
  logic [15:0]           rx_count;
  logic                  count_bad;
  logic                  last_word;

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  load_done;
  logic                  load_error;
  logic                  core_hold;
  logic [ADDR_WIDTH:0]   word_count;
  logic [15:0]           frame_words;
  logic [7:0]            hi_byte;
  logic [7:0]            csum;

  assign accept    = bus.ByteValid & byte_ready;
  assign rx_count  = {frame_words[15:8], bus.ByteData};
  assign count_bad = (rx_count == 16'd0) || ({1'b0, rx_count} > MAX_WORDS);
  assign last_word = (16'(word_count + (ADDR_WIDTH + 1)'(1)) == frame_words);

  assign bus.ByteReady    = byte_ready;
  assign bus.WriteEn      = write_en;
  assign bus.WriteAddress = write_address;
  assign bus.WriteData    = write_data;
  assign bus.LoadDone     = load_done;
  assign bus.LoadError    = load_error;
  assign bus.CoreHold     = core_hold;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; StartLoad restarts from any state and wins over a byte.
  always_comb begin
    next_state = state;
    if (bus.StartLoad) begin
      next_state = SYNC;
    end else if (accept) begin
      case (state)
        SYNC:    if (bus.ByteData == SYNC_BYTE) next_state = CNT_HI;
        CNT_HI:  next_state = CNT_LO;
        CNT_LO:  next_state = count_bad ? ERROR : DATA_HI;
        DATA_HI: next_state = DATA_LO;
        DATA_LO: next_state = last_word ? CHECK : DATA_HI;
        CHECK:   next_state = (bus.ByteData == csum) ? DONE : ERROR;
        default: next_state = state;
      endcase
    end
  end

  // Byte stream ready in the receiving states, masked during a restart cycle.
  always_comb begin
    byte_ready = 1'b0;
    case (state)
      SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK: byte_ready = !bus.StartLoad;
      default: byte_ready = 1'b0;
    endcase
  end

  // Datapath: count capture, word assembly, RAM write strobe, checksum and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      core_hold     <= HOLD_AT_RESET;
      word_count    <= '0;
      frame_words   <= '0;
      hi_byte       <= '0;
      csum          <= '0;
    end else begin
      write_en <= 1'b0;
      if (bus.StartLoad) begin
        core_hold  <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        word_count <= '0;
        csum       <= '0;
      end else if (accept) begin
        case (state)
          CNT_HI: frame_words[15:8] <= bus.ByteData;
          CNT_LO: begin
            frame_words[7:0] <= bus.ByteData;
            if (count_bad) load_error <= 1'b1;
          end
          DATA_HI: begin
            hi_byte <= bus.ByteData;
            csum    <= csum + bus.ByteData;
          end
          DATA_LO: begin
            write_en      <= 1'b1;
            write_address <= word_count[ADDR_WIDTH-1:0];
            write_data    <= DATA_WIDTH'({hi_byte, bus.ByteData});
            word_count    <= word_count + (ADDR_WIDTH + 1)'(1);
            csum          <= csum + bus.ByteData;
          end
          CHECK: begin
            if (bus.ByteData == csum) begin
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
